// File: rtl/compare_arbiter_pkg.sv
// Shared types for the compare arbiter slice.
//   compare_t        : full comparison result bundle returned to requesters
//   cmp_arb_state_t  : arbiter FSM state encoding, also exported for debug
package signals;

    // Field order is MSB first: {eq, neq, gt, lt, gtu, ltu}.
    typedef struct packed {
        logic eq;
        logic neq;
        logic gt;
        logic lt;
        logic gtu;
        logic ltu;
    } compare_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_arb_state_t;

endpackage

// File: rtl/compare_arbiter_if.sv
// Request/response bundle between execute-stage requesters and the arbiter.
//   req_valid/req_ready/req_a/req_b : per-requester request channel
//   resp_valid/resp_ready/resp_signal : per-requester response channel
//   busy : arbiter is not idle
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high. The request side holds valid
// and operands until it sees ready; the response side holds valid and data
// until it sees ready. Operands are only sampled on the transfer edge.
interface compare_arbiter_if #(
    parameter int N    = 32,
    parameter int NREQ = 2
);
    import signals::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    compare_t          resp_signal;
    logic              busy;

    // Requester side.
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_signal, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_signal, busy
    );

endinterface

// File: rtl/comparator_user.sv
// Single N-bit comparator producing the full compare_t bundle.
//   a, b   : operands
//   signal : eq/neq bitwise, gt/lt signed, gtu/ltu unsigned
module comparator_user
    import signals::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output compare_t     signal
);

    always_comb begin
        signal     = '0;
        signal.eq  = (a == b);
        signal.neq = (a != b);
        signal.gt  = ($signed(a) > $signed(b));
        signal.lt  = ($signed(a) < $signed(b));
        signal.gtu = (a > b);
        signal.ltu = (a < b);
    end

endmodule

// File: rtl/compare_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index this round
//   winner  : first set request at or above ptr, wrapping modulo NREQ
//   any_req : at least one request is set
module rr_pick #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    // One extra bit so ptr + k cannot overflow before the modulo fold.
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        sel    = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            sel = sum[IW-1:0];
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin controller sharing one comparator among NREQ requesters.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : request/response bundle (slave side)
//   dbg_state   : current FSM state
//   dbg_rr_ptr  : current round-robin pointer
// Flow: IDLE accepts one winner and latches its operands, CMP registers the
// comparator output, RESP holds the result until the granted requester
// takes it, then the pointer moves past the winner.
module compare_arbiter
    import signals::*;
#(
    parameter  int N    = 32,
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    compare_arbiter_if.slave  bus,
    output cmp_arb_state_t    dbg_state,
    output logic [IW-1:0]     dbg_rr_ptr
);

    cmp_arb_state_t state, state_nx;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant;
    logic [IW-1:0]  winner;
    logic           any_req;
    logic [N-1:0]   op_a, op_b;
    compare_t       cmp_out;
    compare_t       resp_sig_q;
    logic           accept;
    logic           resp_done;
    logic [NREQ-1:0] req_ready_c;
    logic [NREQ-1:0] resp_valid_c;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    comparator_user #(.N(N)) u_cmp (
        .a      (op_a),
        .b      (op_b),
        .signal (cmp_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        resp_done = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept   = 1'b1;
                    state_nx = CMP;
                end
            end
            CMP: begin
                state_nx = RESP;
            end
            RESP: begin
                // Only the granted requester's ready bit can release RESP.
                if (bus.resp_ready[grant]) begin
                    resp_done = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_c  = '0;
        resp_valid_c = '0;
        // Gate with reset so no accept strobe is shown while held in reset.
        if (accept && !reset) begin
            req_ready_c[winner] = 1'b1;
        end
        if (state == RESP) begin
            resp_valid_c[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            grant      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_sig_q <= '0;
        end else begin
            if (accept) begin
                grant <= winner;
                op_a  <= bus.req_a[int'(winner)*N +: N];
                op_b  <= bus.req_b[int'(winner)*N +: N];
            end
            if (state == CMP) begin
                resp_sig_q <= cmp_out;
            end
            if (resp_done) begin
                rr_ptr <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.resp_valid  = resp_valid_c;
    assign bus.resp_signal = resp_sig_q;
    assign bus.busy        = (state != IDLE);
    assign dbg_state       = state;
    assign dbg_rr_ptr      = rr_ptr;

endmodule

// File: tb/tb_compare_arbiter.sv
module tb_compare_arbiter;
    import signals::*;

    localparam int N = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    compare_arbiter_if #(.N(N), .NREQ(2)) if2 ();
    compare_arbiter_if #(.N(N), .NREQ(3)) if3 ();

    cmp_arb_state_t st2, st3;
    logic           ptr2;
    logic [1:0]     ptr3;

    compare_arbiter #(.N(N), .NREQ(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .bus        (if2),
        .dbg_state  (st2),
        .dbg_rr_ptr (ptr2)
    );

    compare_arbiter #(.N(N), .NREQ(3)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .bus        (if3),
        .dbg_state  (st3),
        .dbg_rr_ptr (ptr3)
    );

    // ---------------- scoreboard ----------------
    // Entry: {requester index[1:0], eq, neq, gt, lt, gtu, ltu}
    logic [7:0] exp_q2[$];
    logic [7:0] exp_q3[$];
    logic [7:0] e2, e3;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] model(input logic [31:0] a, input logic [31:0] b);
        logic eq, neq, gt, lt, gtu, ltu;
        eq  = (a == b);
        neq = !eq;
        // Signed order: flip sign bits, then compare unsigned.
        gt  = ({~a[31], a[30:0]} > {~b[31], b[30:0]});
        lt  = ({~a[31], a[30:0]} < {~b[31], b[30:0]});
        gtu = (a > b);
        ltu = (a < b);
        return {eq, neq, gt, lt, gtu, ltu};
    endfunction

    function automatic logic [1:0] first_idx(input logic [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return 2'(i);
        end
        return 2'd3;
    endfunction

    always @(negedge clk) begin
        if (!reset && (if2.resp_valid & if2.resp_ready) != 2'b00) begin
            check("resp2_onehot", 64'($countones(if2.resp_valid)), 1);
            if (exp_q2.size() == 0) begin
                check("resp2_unexpected", {62'b0, if2.resp_valid}, 0);
            end else begin
                e2 = exp_q2.pop_front();
                check("resp2_idx", first_idx({1'b0, if2.resp_valid}), e2[7:6]);
                check("resp2_sig", if2.resp_signal, e2[5:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && (if3.resp_valid & if3.resp_ready) != 3'b000) begin
            check("resp3_onehot", 64'($countones(if3.resp_valid)), 1);
            if (exp_q3.size() == 0) begin
                check("resp3_unexpected", {61'b0, if3.resp_valid}, 0);
            end else begin
                e3 = exp_q3.pop_front();
                check("resp3_idx", first_idx(if3.resp_valid), e3[7:6]);
                check("resp3_sig", if3.resp_signal, e3[5:0]);
            end
        end
    end

    // ---------------- driver tasks (2-requester DUT) ----------------
    task automatic wait_ready2(input int idx, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if2.req_ready[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_ready2_timeout", 0, 1);
    endtask

    task automatic issue2(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] exp_sig);
        bit ok;
        exp_q2.push_back({2'(idx), exp_sig});
        if2.req_a[idx*N +: N] = a;
        if2.req_b[idx*N +: N] = b;
        if2.req_valid[idx]    = 1'b1;
        wait_ready2(idx, ok);
        @(posedge clk);
        #1;
        if2.req_valid[idx] = 1'b0;
    endtask

    task automatic drain2();
        int k;
        k = 0;
        while (exp_q2.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain2", 64'(exp_q2.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        logic [31:0] ra, rb;
        logic [2:0]  rdy3;
        int idx, k;

        if2.req_valid  = '0;
        if2.req_a      = '0;
        if2.req_b      = '0;
        if2.resp_ready = '1;
        if3.req_valid  = '0;
        if3.req_a      = '0;
        if3.req_b      = '0;
        if3.resp_ready = '1;

        // Reset values; requests pending must not be acknowledged in reset.
        reset = 1'b1;
        if2.req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", if2.req_ready, 0);
        check("rst_resp_valid", if2.resp_valid, 0);
        check("rst_resp_signal", if2.resp_signal, 0);
        check("rst_busy", if2.busy, 0);
        check("rst_state", st2, IDLE);
        check("rst_ptr", ptr2, 0);
        if2.req_valid = 2'b00;
        reset = 1'b0;

        // Single request: 5 vs 3, with cycle-exact latency.
        @(posedge clk);
        #1;
        exp_q2.push_back({2'd0, 6'b011010});
        if2.req_a[31:0]  = 32'd5;
        if2.req_b[31:0]  = 32'd3;
        if2.req_valid[0] = 1'b1;
        @(negedge clk);
        check("t1_req_ready", if2.req_ready, 2'b01);
        check("t1_busy_idle", if2.busy, 0);
        @(posedge clk);
        #1;
        if2.req_valid[0] = 1'b0;
        @(negedge clk);
        check("t1_state_cmp", st2, CMP);
        check("t1_no_resp_in_cmp", if2.resp_valid, 0);
        check("t1_no_ready_in_cmp", if2.req_ready, 0);
        check("t1_busy_cmp", if2.busy, 1);
        @(negedge clk);
        check("t1_resp_valid", if2.resp_valid, 2'b01);
        @(negedge clk);
        check("t1_back_idle", st2, IDLE);
        check("t1_ptr_adv", ptr2, 1);
        @(posedge clk);
        #1;

        // Signed vs unsigned.
        issue2(0, 32'hFFFF_FFFF, 32'h0000_0001, 6'b010110);
        drain2();

        // Single active requester re-granted from either pointer value.
        issue2(1, 32'h8000_0000, 32'h7FFF_FFFF, 6'b010110);
        drain2();
        issue2(1, 32'd42, 32'd42, 6'b100000);
        drain2();

        // Random operands on random requesters.
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(0, 1);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            issue2(idx, ra, rb, model(ra, rb));
            drain2();
        end

        // Backpressure: non-granted ready bit set, granted one low.
        if2.resp_ready = 2'b10;
        exp_q2.push_back({2'd0, 6'b010101});
        exp_q2.push_back({2'd1, 6'b100000});
        if2.req_a[31:0]  = 32'd7;
        if2.req_b[31:0]  = 32'd9;
        if2.req_valid[0] = 1'b1;
        wait_ready2(0, ok);
        @(posedge clk);
        #1;
        if2.req_valid[0] = 1'b0;
        if2.req_a[31:0]  = 32'hDEAD_BEEF;
        if2.req_b[31:0]  = 32'd0;
        if2.req_a[63:32] = 32'd100;
        if2.req_b[63:32] = 32'd100;
        if2.req_valid[1] = 1'b1;
        k = 0;
        while (if2.resp_valid[0] !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("bp_resp_seen", if2.resp_valid, 2'b01);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_resp_valid", if2.resp_valid, 2'b01);
            check("bp_resp_signal", if2.resp_signal, 6'b010101);
            check("bp_busy", if2.busy, 1);
            check("bp_req_ready", if2.req_ready, 0);
        end
        @(posedge clk);
        #1;
        if2.resp_ready = 2'b11;
        wait_ready2(1, ok);
        @(posedge clk);
        #1;
        if2.req_valid[1] = 1'b0;
        drain2();

        // Reset during CMP: set pointer to 1 first, then abort a req 1.
        issue2(0, 32'd1, 32'd2, 6'b010101);
        drain2();
        check("rst_mid_ptr_before", ptr2, 1);
        if2.req_a[63:32] = 32'd3;
        if2.req_b[63:32] = 32'd4;
        if2.req_valid[1] = 1'b1;
        wait_ready2(1, ok);
        @(posedge clk);
        #1;
        if2.req_valid[1] = 1'b0;
        @(negedge clk);
        check("rst_mid_in_cmp", st2, CMP);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_state", st2, IDLE);
        check("rst_mid_busy", if2.busy, 0);
        check("rst_mid_resp_valid", if2.resp_valid, 0);
        check("rst_mid_resp_signal", if2.resp_signal, 0);
        check("rst_mid_ptr", ptr2, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_hold_resp", if2.resp_valid, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        issue2(1, 32'd3, 32'd4, 6'b010101);
        drain2();

        // Contention: pointer is 0 here, grants must go 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            exp_q2.push_back({2'(i % 2), 6'b100000});
        end
        if2.req_a     = {32'h1234, 32'h1234};
        if2.req_b     = {32'h1234, 32'h1234};
        if2.req_valid = 2'b11;
        k = 0;
        while (exp_q2.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if2.req_valid = 2'b00;
        check("cont_drained", 64'(exp_q2.size()), 0);
        repeat (4) @(negedge clk);
        check("cont_idle_after", if2.busy, 0);

        // Three requesters: 2 alone, then 0 and 1 together -> 2, 0, 1.
        exp_q3.push_back({2'd2, 6'b010101});
        exp_q3.push_back({2'd0, 6'b010110});
        exp_q3.push_back({2'd1, 6'b100000});
        if3.req_a = {32'd10, 32'd9, 32'hFFFF_FFFB};
        if3.req_b = {32'd20, 32'd9, 32'd3};
        @(posedge clk);
        #1;
        if3.req_valid = 3'b100;
        k = 0;
        while (exp_q3.size() != 0 && k < 60) begin
            @(negedge clk);
            rdy3 = if3.req_ready;
            @(posedge clk);
            #1;
            if (rdy3[2]) begin
                if3.req_valid[2]   = 1'b0;
                if3.req_valid[1:0] = 2'b11;
            end
            if (rdy3[0]) if3.req_valid[0] = 1'b0;
            if (rdy3[1]) if3.req_valid[1] = 1'b0;
            k++;
        end
        check("wrap_drained", 64'(exp_q3.size()), 0);
        @(negedge clk);
        check("wrap_final_ptr", ptr3, 2);
        check("wrap_idle", st3, IDLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Round-robin controller that shares one N-bit comparator among NREQ requesters, e.g. branch resolution and set-less-than units.
- Each request is accepted by valid/ready handshake, evaluated on latched operands, and answered on a per-requester response handshake.
- The response carries a full signals::compare_t.
- Sits between the execute-stage consumers and a single comparator_user instance.

Parameters:
- N, 32, operand width in bits.
- NREQ, 2, number of requesters (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept strobe; at most one bit set.
- req_a  input  NREQ*N  operand a; requester i uses bits [i*N +: N].
- req_b  input  NREQ*N  operand b, same packing.
- resp_valid  output  NREQ  per-requester result valid; at most one bit set.
- resp_ready  input  NREQ  per-requester result accept.
- resp_signal  output  compare_t  result (eq, neq, gt, lt, gtu, ltu) for the requester whose resp_valid bit is set.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant=0, resp_valid=0, resp_signal=all zero, busy=0. req_ready=0 while reset is high.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If any req_valid bit is set, pick the winner: scan from rr_ptr upward, wrap modulo NREQ, take the first set bit.
  - req_ready[winner]=1 combinationally in the same cycle.
  - On that clock edge, latch req_a/req_b slices into op_a/op_b, set grant=winner, go to CMP.
  - No request: stay in IDLE, req_ready=0.
- CMP:
  - The comparator sees op_a/op_b.
  - On the clock edge its output is registered into resp_signal and the FSM goes to RESP.
  - req_ready=0.
- RESP:
  - resp_valid[grant]=1, resp_signal held stable.
  - When resp_ready[grant]=1 on a clock edge: clear resp_valid, set rr_ptr=(grant+1) mod NREQ, go to IDLE.
  - resp_ready bits of non-granted requesters are ignored.
- Latency: accept edge at cycle t gives resp_valid high in cycle t+2. Minimum issue interval is 3 cycles.
- Operand stability: operands are sampled only on the accept edge. Later changes to req_a/req_b have no effect on the in-flight result.
- Request protocol: a requester holds req_valid high until it sees req_ready. A deasserted req_valid before grant is simply dropped, and no error is flagged.
- Simultaneous requests: exactly one is granted. The loser keeps req_valid high and is granted next, because the pointer advances past the winner.
- Single active requester: it is re-granted every transaction, whatever rr_ptr is.
- rr_ptr wrap: at grant=NREQ-1, rr_ptr wraps to 0.
- Comparison semantics:
  - gt/lt: two's-complement signed.
  - gtu/ltu: unsigned.
  - eq/neq: bitwise.
  - Results must match comparator_user for all inputs.
- Reset mid-operation: asserting reset in CMP or RESP aborts the transaction immediately. No response is delivered, and the requester must re-issue.
- Stalled response: resp_ready held low keeps the FSM in RESP indefinitely. All req_ready stay 0, and no new request is accepted.

Decomposition:
- Package signals:
  - add cmp_arb_state_t enum {IDLE, CMP, RESP}.
  - compare_t already lives there and is reused.
- Sub-module rr_pick #(NREQ):
  - combinational round-robin priority picker.
  - inputs: request vector and rr_ptr.
  - outputs: winner index and any_req.
- The comparator is an instance of comparator_user #(N); no new compare logic.

Test Plan:
- Single request: only req 0, a=5, b=3. req_ready[0] high in the accept cycle; resp_valid[0] two cycles later with gt=1, gtu=1, eq=0, lt=0. Returns to IDLE after resp_ready[0].
- Signed vs unsigned: a=0xFFFFFFFF, b=0x00000001. Response has lt=1, gt=0, gtu=1, ltu=0, neq=1.
- Contention fairness: req 0 and req 1 valid continuously with equal operands 0x1234. Grants alternate 0,1,0,1; every response has eq=1, neq=0.
- Backpressure and operand change: hold resp_ready low for 10 cycles.
  - resp_valid and resp_signal stay stable and busy=1.
  - req_ready stays 0 for a pending req 1.
  - Changing req_a after accept leaves the result unchanged.
- Reset mid-operation: assert reset during CMP. Outputs go to reset values asynchronously, with no resp_valid and rr_ptr=0. A re-issued request completes normally.
- Wrap-around with NREQ=3: requests on 2 then 0 and 1 simultaneously. After grant 2, the pointer wraps to 0, so order is 2, 0, 1.
